// File: rtl/bcd_convert_ctrl.sv
// Sequential binary-to-BCD converter: repeated compare/subtract against 100, then 10.
// Start/Busy/Done handshake; the last result stays registered until the next one completes.
module bcd_convert_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Bin,
    output logic             Busy,
    output logic             Done,
    output logic [3:0]       Hundreds,
    output logic [3:0]       Tens,
    output logic [3:0]       Ones
);

    typedef enum logic [1:0] {
        IDLE,
        SUB100,
        SUB10,
        DONE
    } state_t;

    state_t     state, state_next;
    logic [9:0] r, r_next;
    logic [3:0] hc, hc_next;
    logic [3:0] tc, tc_next;
    logic       load_digits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            r     <= '0;
            hc    <= '0;
            tc    <= '0;
        end else begin
            state <= state_next;
            r     <= r_next;
            hc    <= hc_next;
            tc    <= tc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Hundreds <= '0;
            Tens     <= '0;
            Ones     <= '0;
        end else if (load_digits) begin
            Hundreds <= hc;
            Tens     <= tc;
            Ones     <= r[3:0];
        end
    end

    always_comb begin
        state_next  = state;
        r_next      = r;
        hc_next     = hc;
        tc_next     = tc;
        load_digits = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    r_next     = 10'(Bin);
                    hc_next    = '0;
                    tc_next    = '0;
                    state_next = SUB100;
                end
            end
            SUB100: begin
                if (r >= 10'd100) begin
                    r_next  = r - 10'd100;
                    hc_next = hc + 4'd1;
                end else begin
                    state_next = SUB10;
                end
            end
            SUB10: begin
                if (r >= 10'd10) begin
                    r_next  = r - 10'd10;
                    tc_next = tc + 4'd1;
                end else begin
                    // Remainder is now below 10, so r[3:0] is the ones digit.
                    load_digits = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Self-checking bench: directed latency/digit tests plus random Start/Bin traffic,
// all compared each cycle against an arithmetic (div/mod) reference model.
module tb_bcd_convert_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] Bin = '0;
    logic       Busy, Done;
    logic [3:0] Hundreds, Tens, Ones;

    int errors = 0;
    int checks = 0;

    bcd_convert_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Start    (Start),
        .Bin      (Bin),
        .Busy     (Busy),
        .Done     (Done),
        .Hundreds (Hundreds),
        .Tens     (Tens),
        .Ones     (Ones)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: digits from div/mod, Done cycle from the H+T+2 latency rule.
    int cyc = 0;
    bit m_busy = 0;
    int m_done_cyc = 0;
    int m_h = 0, m_t = 0, m_o = 0;
    int o_h = 0, o_t = 0, o_o = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; m_busy = 0; m_done_cyc = 0;
            o_h = 0; o_t = 0; o_o = 0;
        end else begin
            cyc++;
            if (m_busy) begin
                if (cyc == m_done_cyc) begin
                    o_h = m_h; o_t = m_t; o_o = m_o;
                end else if (cyc == m_done_cyc + 1) begin
                    m_busy = 0;
                end
            end else if (Start) begin
                m_h = int'(Bin) / 100;
                m_t = (int'(Bin) % 100) / 10;
                m_o = int'(Bin) % 10;
                m_done_cyc = cyc + m_h + m_t + 2;
                m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", int'(Busy), int'(m_busy));
        check("done", int'(Done), int'(m_busy && cyc == m_done_cyc));
        check("hundreds", int'(Hundreds), o_h);
        check("tens", int'(Tens), o_t);
        check("ones", int'(Ones), o_o);
        if (Done && !Busy) check("done_implies_busy", 0, 1);
    end

    // One conversion from IDLE; optionally re-pulses Start with 37 while busy.
    task automatic convert(input logic [7:0] b, input int eh, input int et, input int eo,
                           input int elat, input bit repulse);
        int lat;
        int ndone;
        bit seen;
        @(negedge clk);
        Start = 1'b1;
        Bin   = b;
        @(posedge clk);
        @(negedge clk);
        if (repulse) begin
            Bin = 8'd37;
        end else begin
            Start = 1'b0;
            Bin   = 8'($urandom);
        end
        lat = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            if (Done) begin
                seen = 1;
            end else begin
                @(negedge clk);
                lat++;
                if (repulse && lat == 1) Start = 1'b0;
            end
        end
        check("done_seen", int'(seen), 1);
        check("latency", lat, elat);
        check("dir_hundreds", int'(Hundreds), eh);
        check("dir_tens", int'(Tens), et);
        check("dir_ones", int'(Ones), eo);
        @(negedge clk);
        check("busy_after_done", int'(Busy), 0);
        if (repulse) begin
            ndone = 0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (Done) ndone++;
            end
            check("no_second_done", ndone, 0);
            check("repulse_hold_hundreds", int'(Hundreds), eh);
        end
    endtask

    initial begin
        int last_done;
        int pulses;
        int budget;

        // Reset asserted mid-cycle after a clean start.
        #2;
        check("reset_busy", int'(Busy), 0);
        check("reset_ones", int'(Ones), 0);
        #20 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_busy", int'(Busy), 0);
            check("idle_done", int'(Done), 0);
        end

        convert(8'd0,   0, 0, 0, 2,  0);
        convert(8'd255, 2, 5, 5, 9,  0);
        convert(8'd199, 1, 9, 9, 12, 0);
        convert(8'd100, 1, 0, 0, 3,  1);

        // Start held high: back-to-back conversions spaced H+T+4 apart.
        @(negedge clk);
        Start = 1'b1;
        Bin   = 8'd42;
        pulses = 0;
        last_done = 0;
        budget = 0;
        while (pulses < 3 && budget < 60) begin
            @(negedge clk);
            budget++;
            if (Done) begin
                if (pulses > 0) check("rearm_spacing", budget - last_done, 8);
                check("rearm_tens", int'(Tens), 4);
                check("rearm_ones", int'(Ones), 2);
                last_done = budget;
                pulses++;
            end
        end
        check("rearm_pulses", pulses, 3);
        Start = 1'b0;
        while (Busy && budget < 100) begin
            @(negedge clk);
            budget++;
        end

        // Abort 150 while in SUB10 (edge 4 after accept), then convert 64.
        @(negedge clk);
        Start = 1'b1;
        Bin   = 8'd150;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(Busy), 0);
        check("abort_done", int'(Done), 0);
        check("abort_hundreds", int'(Hundreds), 0);
        check("abort_tens", int'(Tens), 0);
        check("abort_ones", int'(Ones), 0);
        #15 rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("abort_no_done", int'(Done), 0);
        end
        convert(8'd64, 0, 6, 4, 8, 0);

        // Random traffic; the per-cycle model compare does the checking.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            Start = ($urandom_range(0, 3) == 0);
            Bin   = 8'($urandom);
        end
        Start = 1'b0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
